inference_ctrl: RTL and testbench
=================================

INFERENCE_CTRL -- requirements
Module: inference_ctrl

Interface
REQ-001 The block SHALL have parameter INPUT_SIZE, default 4, giving the number of integer inputs driven into the network.
REQ-002 The block SHALL have parameter OUTPUT_SIZE, default 3, giving the number of integer results read back from the network.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 8, giving the number of bitstream warm-up cycles before the integration window opens.
REQ-004 The block SHALL have parameter WINDOW, default 256, giving the integration window length in cycles.
REQ-005 The block SHALL have parameter MAX_VAL, default 256, giving the upper clamp for input values.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 Port clk SHALL be an input, 1 bit: the sole clock.
REQ-008 Port n_rst SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-009 Port in_valid SHALL be an input, 1 bit: an input word is offered.
REQ-010 Port in_ready SHALL be an output, 1 bit: the block accepts the offered word.
REQ-011 Port in_data SHALL be an input int (32-bit signed): the input value, taken in index order 0..INPUT_SIZE-1.
REQ-012 Port net_input SHALL be an output int array [0:INPUT_SIZE-1]: drives the network input vector.
REQ-013 Port net_compute SHALL be an output, 1 bit: the integration window boundary strobe to the network.
REQ-014 Port net_output SHALL be an input int array [0:OUTPUT_SIZE-1]: the network integrator results.
REQ-015 Port res_valid SHALL be an output, 1 bit: a result is held.
REQ-016 Port res_ready SHALL be an input, 1 bit: the consumer takes the result.
REQ-017 Port res_data SHALL be an output int array [0:OUTPUT_SIZE-1]: the captured results.
REQ-018 Port res_class SHALL be an output, $clog2(OUTPUT_SIZE) bits wide: the argmax index.
REQ-019 Port busy SHALL be an output, 1 bit: high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, SETTLE, RUN, CAPTURE and HOLD.
REQ-021 In IDLE, in_ready SHALL be 1, and each in_valid&&in_ready word SHALL be written to net_input[idx], after which idx increments.
REQ-022 Each accepted word SHALL be clamped before it is stored: values below 0 store as 0, values above MAX_VAL store as MAX_VAL.
REQ-023 The INPUT_SIZE-th accepted word SHALL move the FSM to SETTLE, reset idx to 0 and clear the cycle counter.
REQ-024 Outside IDLE, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-025 Timing is counted with the last input handshake as cycle 0:
- SETTLE SHALL occupy cycles 1..SETTLE_CYCLES.
- RUN SHALL occupy cycles SETTLE_CYCLES+1..SETTLE_CYCLES+WINDOW.
- CAPTURE SHALL occupy cycle SETTLE_CYCLES+WINDOW+1.
REQ-026 net_compute SHALL be high for exactly two cycles per inference: the first RUN cycle and the CAPTURE cycle.
REQ-027 In CAPTURE, res_data SHALL register net_output; res_valid SHALL be 1 from cycle SETTLE_CYCLES+WINDOW+2.
REQ-028 In HOLD, res_valid, res_data and res_class SHALL stay stable until res_valid&&res_ready; the FSM SHALL then return to IDLE, with res_valid going 0 in the next cycle.
REQ-029 net_input SHALL stay constant from SETTLE through HOLD.
REQ-030 res_data SHALL keep its last value after the handshake until the next CAPTURE.
REQ-031 The cycle counter SHALL be $clog2(WINDOW+SETTLE_CYCLES+1) bits wide and SHALL never wrap.
REQ-032 When SETTLE_CYCLES=0, RUN SHALL start in cycle 1.

Reset
REQ-033 When n_rst=0, the following SHALL apply asynchronously at any time, including mid-window:
- state SHALL be IDLE and idx SHALL be 0;
- net_input, res_data and res_class SHALL be all zeros;
- res_valid, net_compute and busy SHALL be 0;
- in_ready SHALL be 1 after release.
REQ-034 Words accepted before a reset SHALL be discarded.

Configuration
REQ-035 With INFERENCE_CTRL_ARGMAX_EN defined, res_class SHALL be registered in CAPTURE as the index of the maximum value in net_output, with ties going to the lowest index.
REQ-036 Without INFERENCE_CTRL_ARGMAX_EN, res_class SHALL be tied to 0 and no comparator logic SHALL exist.

Structure
REQ-037 The shared package bitstream_pkg SHALL hold the FSM state enum, the MAX_VAL default and the clamp function.
REQ-038 The argmax comparator SHALL be the sub-module argmax_unit, which is combinational and instantiated only under INFERENCE_CTRL_ARGMAX_EN.

Verification
REQ-039 With SETTLE_CYCLES=8, WINDOW=256, load {10,20,30,40}: net_input={10,20,30,40}; net_compute is high at cycles 9 and 265; res_valid rises at cycle 266.
REQ-040 Load {-5,300,256,0}: net_input={0,256,256,0}.
REQ-041 With net_output={12,90,90} at CAPTURE and the macro defined: res_data={12,90,90} and res_class=1; without the macro, res_class=0.
REQ-042 Hold res_ready=0 for 50 cycles after res_valid, and drive in_valid=1 throughout: res_data is stable, in_ready=0 and no words are accepted; pulse res_ready and then in_ready=1 on the next cycle.
REQ-043 Assert n_rst=0 at cycle 100 of RUN: all outputs reset immediately; after release, a fresh 4-word load completes normally.
REQ-044 Drive in_valid with gaps (1,0,1,0,...): exactly 4 accepted words start SETTLE, and the timing is counted from the 4th handshake.

Source files
------------

// File: rtl/bitstream_pkg.sv
// rtl/bitstream_pkg.sv - shared FSM state type, input clamp default and clamp helper
package bitstream_pkg;

    localparam int MAX_VAL_DEFAULT = 256;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RUN,
        CAPTURE,
        HOLD
    } state_t;

    // Saturate an input word into the range the bitstream encoders can represent.
    function automatic int clamp(input int value, input int max_val);
        int result;
        result = value;
        if (value < 0) begin
            result = 0;
        end else if (value > max_val) begin
            result = max_val;
        end
        return result;
    endfunction

endpackage

// File: rtl/argmax_unit.sv
// rtl/argmax_unit.sv - combinational argmax over the integrator results, ties to lowest index
module argmax_unit #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  int               i_data [0:N-1],
    output logic [IW-1:0]    o_idx
);

    int w_best;

    always_comb begin
        w_best = i_data[0];
        o_idx  = '0;
        // Strict compare keeps the earliest index on equal values.
        for (int i = 1; i < N; i++) begin
            if (i_data[i] > w_best) begin
                w_best = i_data[i];
                o_idx  = IW'(i);
            end
        end
    end

endmodule

// File: rtl/inference_ctrl.sv
// rtl/inference_ctrl.sv - loads inputs, times settle/integration window, captures results
// Optional argmax classification of the captured results under INFERENCE_CTRL_ARGMAX_EN.
module inference_ctrl
    import bitstream_pkg::*;
#(
    parameter int INPUT_SIZE    = 4,
    parameter int OUTPUT_SIZE   = 3,
    parameter int SETTLE_CYCLES = 8,
    parameter int WINDOW        = 256,
    parameter int MAX_VAL       = MAX_VAL_DEFAULT
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  int                             in_data,
    output int                             net_input  [0:INPUT_SIZE-1],
    output logic                           net_compute,
    input  int                             net_output [0:OUTPUT_SIZE-1],
    output logic                           res_valid,
    input  logic                           res_ready,
    output int                             res_data   [0:OUTPUT_SIZE-1],
    output logic [$clog2(OUTPUT_SIZE)-1:0] res_class,
    output logic                           busy
);

    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int CNT_W = $clog2(WINDOW + SETTLE_CYCLES + 1);
    localparam int CLS_W = $clog2(OUTPUT_SIZE);

    // Counter value during cycle c (last handshake = cycle 0) is c-1.
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_START  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] RUN_END    = CNT_W'(SETTLE_CYCLES + WINDOW - 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    int                 r_net_input [0:INPUT_SIZE-1];
    int                 r_res_data  [0:OUTPUT_SIZE-1];
    logic               w_accept;
    logic               w_last;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = w_accept && (r_idx == IDX_W'(INPUT_SIZE - 1));
    assign net_input = r_net_input;
    assign res_data  = r_res_data;

    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        net_compute = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_last) begin
                    w_next = (SETTLE_CYCLES == 0) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == SETTLE_END) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                net_compute = (r_cnt == RUN_START);
                if (r_cnt == RUN_END) begin
                    w_next = CAPTURE;
                end
            end
            CAPTURE: begin
                net_compute = 1'b1;
                w_next      = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                r_net_input[i] <= 0;
            end
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                r_res_data[i] <= 0;
            end
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_net_input[r_idx] <= clamp(in_data, MAX_VAL);
                r_idx              <= w_last ? '0 : r_idx + IDX_W'(1);
            end
            // Stops at SETTLE_CYCLES+WINDOW, which the counter width holds without wrapping.
            if (w_last) begin
                r_cnt <= '0;
            end else if (r_state == SETTLE || r_state == RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == CAPTURE) begin
                for (int i = 0; i < OUTPUT_SIZE; i++) begin
                    r_res_data[i] <= net_output[i];
                end
            end
        end
    end

`ifdef INFERENCE_CTRL_ARGMAX_EN
    logic [CLS_W-1:0] w_argmax;
    logic [CLS_W-1:0] r_class;

    argmax_unit #(
        .N  (OUTPUT_SIZE),
        .IW (CLS_W)
    ) u_argmax (
        .i_data (net_output),
        .o_idx  (w_argmax)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_class <= '0;
        end else if (r_state == CAPTURE) begin
            r_class <= w_argmax;
        end
    end

    assign res_class = r_class;
`else
    assign res_class = '0;
`endif

endmodule

// File: tb/tb_inference_ctrl.sv
// tb/tb_inference_ctrl.sv - directed self-checking bench for inference_ctrl
module tb_inference_ctrl;

    localparam int IN  = 4;
    localparam int OUT = 3;
    localparam int S   = 8;
    localparam int W   = 256;
`ifdef INFERENCE_CTRL_ARGMAX_EN
    localparam bit ARGMAX = 1'b1;
`else
    localparam bit ARGMAX = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    int         in_data = 0;
    int         net_input  [0:IN-1];
    logic       net_compute;
    int         net_output [0:OUT-1];
    logic       res_valid;
    logic       res_ready = 1'b0;
    int         res_data   [0:OUT-1];
    logic [1:0] res_class;
    logic       busy;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    inference_ctrl #(
        .INPUT_SIZE    (IN),
        .OUTPUT_SIZE   (OUT),
        .SETTLE_CYCLES (S),
        .WINDOW        (W),
        .MAX_VAL       (256)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .net_input   (net_input),
        .net_compute (net_compute),
        .net_output  (net_output),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_class   (res_class),
        .busy        (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 1 (the last handshake edge ends cycle 0).
    task automatic load(input int w0, input int w1, input int w2, input int w3, input bit gaps);
        int w [4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = w[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        tick();
        tick();
        vecs++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy);
        if (busy !== 1'b0) errs++;
        vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
        vecs++; if (net_compute !== 1'b0) begin errs++; $display("FAIL reset_net_compute got %b exp 0", net_compute); end
        vecs++; if (res_class !== 2'd0) begin errs++; $display("FAIL reset_res_class got %0d exp 0", res_class); end
        for (int i = 0; i < IN; i++) begin
            vecs++; if (net_input[i] !== 0) begin errs++; $display("FAIL reset_net_input[%0d] got %0d exp 0", i, net_input[i]); end
        end
        for (int i = 0; i < OUT; i++) begin
            vecs++; if (res_data[i] !== 0) begin errs++; $display("FAIL reset_res_data[%0d] got %0d exp 0", i, res_data[i]); end
        end
        n_rst = 1'b1;
        tick();
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_timing;
        int exp_in [4];
        int exp_res [3];
        exp_in  = '{10, 20, 30, 40};
        exp_res = '{12, 90, 90};
        net_output = '{12, 90, 90};
        load(10, 20, 30, 40, 1'b0);
        for (int i = 0; i < IN; i++) begin
            vecs++; if (net_input[i] !== exp_in[i]) begin errs++; $display("FAIL load_net_input[%0d] got %0d exp %0d", i, net_input[i], exp_in[i]); end
        end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL load_busy got %b exp 1", busy); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL load_in_ready got %b exp 0", in_ready); end
        for (int c = 1; c <= S + W + 2; c++) begin
            vecs++;
            if (net_compute !== ((c == S + 1) || (c == S + W + 1))) begin
                errs++; $display("FAIL timing_net_compute cycle %0d got %b", c, net_compute);
            end
            vecs++;
            if (res_valid !== (c >= S + W + 2)) begin
                errs++; $display("FAIL timing_res_valid cycle %0d got %b", c, res_valid);
            end
            if (c < S + W + 2) tick();
        end
        for (int i = 0; i < OUT; i++) begin
            vecs++; if (res_data[i] !== exp_res[i]) begin errs++; $display("FAIL timing_res_data[%0d] got %0d exp %0d", i, res_data[i], exp_res[i]); end
        end
        vecs++;
        if (res_class !== (ARGMAX ? 2'd1 : 2'd0)) begin
            errs++; $display("FAIL timing_res_class got %0d exp %0d", res_class, ARGMAX ? 1 : 0);
        end
    endtask

    task automatic test_hold_backpressure;
        int exp_res [3];
        exp_res = '{12, 90, 90};
        net_output = '{1, 2, 3};
        in_valid   = 1'b1;
        in_data    = 77;
        for (int c = 0; c < 50; c++) begin
            vecs++; if (res_valid !== 1'b1) begin errs++; $display("FAIL hold_res_valid cycle %0d got %b exp 1", c, res_valid); end
            vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL hold_in_ready cycle %0d got %b exp 0", c, in_ready); end
            for (int i = 0; i < OUT; i++) begin
                vecs++; if (res_data[i] !== exp_res[i]) begin errs++; $display("FAIL hold_res_data[%0d] got %0d exp %0d", i, res_data[i], exp_res[i]); end
            end
            vecs++;
            if (res_class !== (ARGMAX ? 2'd1 : 2'd0)) begin
                errs++; $display("FAIL hold_res_class got %0d", res_class);
            end
            vecs++; if (net_input[0] !== 10) begin errs++; $display("FAIL hold_net_input got %0d exp 10", net_input[0]); end
            tick();
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL release_res_valid got %b exp 0", res_valid); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL release_busy got %b exp 0", busy); end
        vecs++; if (net_input[0] !== 10) begin errs++; $display("FAIL release_net_input got %0d exp 10", net_input[0]); end
        for (int i = 0; i < OUT; i++) begin
            vecs++; if (res_data[i] !== exp_res[i]) begin errs++; $display("FAIL release_res_data[%0d] got %0d exp %0d", i, res_data[i], exp_res[i]); end
        end
    endtask

    task automatic test_clamp_gaps;
        int exp_in [4];
        exp_in = '{0, 256, 256, 0};
        net_output = '{5, 5, 2};
        load(-5, 300, 256, 0, 1'b1);
        for (int i = 0; i < IN; i++) begin
            vecs++; if (net_input[i] !== exp_in[i]) begin errs++; $display("FAIL clamp_net_input[%0d] got %0d exp %0d", i, net_input[i], exp_in[i]); end
        end
        for (int c = 1; c <= S + W + 2; c++) begin
            vecs++;
            if (net_compute !== ((c == S + 1) || (c == S + W + 1))) begin
                errs++; $display("FAIL gaps_net_compute cycle %0d got %b", c, net_compute);
            end
            vecs++;
            if (res_valid !== (c >= S + W + 2)) begin
                errs++; $display("FAIL gaps_res_valid cycle %0d got %b", c, res_valid);
            end
            if (c < S + W + 2) tick();
        end
        vecs++; if (res_class !== 2'd0) begin errs++; $display("FAIL tie_res_class got %0d exp 0", res_class); end
        vecs++; if (res_data[1] !== 5) begin errs++; $display("FAIL gaps_res_data got %0d exp 5", res_data[1]); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL gaps_release_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_reset_mid_run;
        int exp_in [4];
        int exp_res [3];
        exp_in  = '{4, 3, 2, 1};
        exp_res = '{7, 3, 9};
        net_output = '{7, 3, 9};
        load(1, 2, 3, 4, 1'b0);
        for (int c = 1; c < S + 100; c++) tick();
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL midrun_busy got %b exp 1", busy); end
        n_rst = 1'b0;
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL async_busy got %b exp 0", busy); end
        vecs++; if (net_compute !== 1'b0) begin errs++; $display("FAIL async_net_compute got %b exp 0", net_compute); end
        vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL async_res_valid got %b exp 0", res_valid); end
        vecs++; if (res_class !== 2'd0) begin errs++; $display("FAIL async_res_class got %0d exp 0", res_class); end
        for (int i = 0; i < IN; i++) begin
            vecs++; if (net_input[i] !== 0) begin errs++; $display("FAIL async_net_input[%0d] got %0d exp 0", i, net_input[i]); end
        end
        for (int i = 0; i < OUT; i++) begin
            vecs++; if (res_data[i] !== 0) begin errs++; $display("FAIL async_res_data[%0d] got %0d exp 0", i, res_data[i]); end
        end
        tick();
        n_rst = 1'b1;
        tick();
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
        load(4, 3, 2, 1, 1'b0);
        for (int i = 0; i < IN; i++) begin
            vecs++; if (net_input[i] !== exp_in[i]) begin errs++; $display("FAIL reload_net_input[%0d] got %0d exp %0d", i, net_input[i], exp_in[i]); end
        end
        for (int c = 1; c <= S + W + 2; c++) begin
            vecs++;
            if (net_compute !== ((c == S + 1) || (c == S + W + 1))) begin
                errs++; $display("FAIL reload_net_compute cycle %0d got %b", c, net_compute);
            end
            if (c < S + W + 2) tick();
        end
        vecs++; if (res_valid !== 1'b1) begin errs++; $display("FAIL reload_res_valid got %b exp 1", res_valid); end
        for (int i = 0; i < OUT; i++) begin
            vecs++; if (res_data[i] !== exp_res[i]) begin errs++; $display("FAIL reload_res_data[%0d] got %0d exp %0d", i, res_data[i], exp_res[i]); end
        end
        vecs++;
        if (res_class !== (ARGMAX ? 2'd2 : 2'd0)) begin
            errs++; $display("FAIL reload_res_class got %0d exp %0d", res_class, ARGMAX ? 2 : 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        net_output = '{0, 0, 0};
        test_reset();
        test_timing();
        test_hold_backpressure();
        test_clamp_gaps();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
